hilbert_envelope_cordic: RTL and testbench

- Downstream of the Hilbert stage. Consumes the analytic pair: the real part from the 31-sample delay line and the quadrature part from the 63-tap Hilbert FIR.
- Computes the instantaneous envelope sqrt(I^2+Q^2) with an iterative, multiplier-free CORDIC in vectoring mode, plus one final gain-compensation multiply.
- Output feeds the envelope follower and visualiser path.
- Samples arrive at audio rate, far slower than clk, so one iteration per clock is sufficient.

---
 rtl/hilbert_envelope_cordic.sv | 250 +++++++++++++++++++++++++
 tb/tb_hilbert_envelope_cordic.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilbert_envelope_cordic.sv
// -----------------------------------------------------------------------------
// hilbert_envelope_cordic
//
// Purpose:
//   Computes the instantaneous envelope sqrt(I^2 + Q^2) of the analytic pair
//   produced by the Hilbert stage. The real part comes from the 31-sample
//   delay line and the quadrature part comes from the 63-tap Hilbert FIR. An
//   iterative vectoring-mode CORDIC performs one micro-rotation per clock. A
//   single gain-compensation multiply follows. Samples arrive at audio rate,
//   so the sequential structure is more than fast enough.
//
// Parameters:
//   ITERS  number of CORDIC micro-rotations (8..16)
//   IW     internal x/y width (16 input bits + 2 growth bits)
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   i_in       signed real part (delay line dout)
//   q_in       signed quadrature part (Hilbert FIR output)
//   valid_in   pair valid for one clk; i_in and q_in are sampled together
//   mag_out    unsigned envelope magnitude, held between results
//   valid_out  one-cycle pulse when mag_out updates
//   busy       high whenever a computation is in flight
//   drop_cnt   saturating count of valid_in pulses ignored while busy
//   phase_out  (only with HILBERT_ENV_PHASE_OUT_EN) signed binary angle,
//              where -32768 = -pi and 16384 = +pi/2
//
// Build option:
//   Define HILBERT_ENV_PHASE_OUT_EN to add the angle accumulator, the atan
//   table and the phase_out port. Without it, only the magnitude is produced,
//   with identical timing.
//
// Timing: the accept edge is edge 0. PRE runs on edge 1 and ROT runs on
// edges 2..ITERS+1. SCALE updates mag_out and valid_out on edge ITERS+2.
// -----------------------------------------------------------------------------
module hilbert_envelope_cordic #(
  parameter int ITERS = 14,
  parameter int IW    = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  input  logic               valid_in,
  output logic        [15:0] mag_out,
  output logic               valid_out,
  output logic               busy,
  output logic        [7:0]  drop_cnt
`ifdef HILBERT_ENV_PHASE_OUT_EN
  ,
  output logic signed [15:0] phase_out
`endif
);

  // Product of an IW-bit x with the 17-bit (positive) gain constant.
  localparam int PW = IW + 17;
  // round(0.607253 * 2^16): inverse of the accumulated CORDIC gain.
  localparam logic signed [16:0] GAIN = 17'sd39797;

  if (ITERS < 8 || ITERS > 16) begin : g_bad_iters
    $error("hilbert_envelope_cordic: ITERS must be in 8..16");
  end
  if (IW < 18) begin : g_bad_iw
    $error("hilbert_envelope_cordic: IW must be at least 18");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    ROT   = 2'd2,
    SCALE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic signed [IW-1:0] x_q, x_d;
  logic signed [IW-1:0] y_q, y_d;
  logic        [3:0]    k_q, k_d;
  logic        [15:0]   mag_q, mag_d;
  logic                 vld_q, vld_d;
  logic        [7:0]    drop_q, drop_d;

  logic signed [IW-1:0] xs, ys;
  logic signed [PW-1:0] prod;

`ifdef HILBERT_ENV_PHASE_OUT_EN
  logic signed [16:0]   z_q, z_d;
  logic signed [15:0]   phase_q, phase_d;

  // atan(2^-k) in binary-angle units (pi = 32768), rounded.
  function automatic logic signed [16:0] atan_lut(input logic [3:0] k);
    logic signed [16:0] a;
    case (k)
      4'd0:    a = 17'sd8192;
      4'd1:    a = 17'sd4836;
      4'd2:    a = 17'sd2555;
      4'd3:    a = 17'sd1297;
      4'd4:    a = 17'sd651;
      4'd5:    a = 17'sd326;
      4'd6:    a = 17'sd163;
      4'd7:    a = 17'sd81;
      4'd8:    a = 17'sd41;
      4'd9:    a = 17'sd20;
      4'd10:   a = 17'sd10;
      4'd11:   a = 17'sd5;
      4'd12:   a = 17'sd3;
      4'd13:   a = 17'sd1;
      4'd14:   a = 17'sd1;
      default: a = 17'sd0;
    endcase
    return a;
  endfunction
`endif

  // Drop the 16 fractional bits of the gain product and clamp the result to
  // the unsigned 16-bit output range.
  function automatic logic [15:0] scale_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    logic        [15:0]   r;
    s = p >>> 16;
    if (s[PW-1]) begin
      r = 16'd0;
    end else if (|s[PW-2:16]) begin
      r = 16'hFFFF;
    end else begin
      r = s[15:0];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    mag_d   = mag_q;
    vld_d   = 1'b0;
    drop_d  = drop_q;
`ifdef HILBERT_ENV_PHASE_OUT_EN
    z_d     = z_q;
    phase_d = phase_q;
`endif
    // Both ROT updates use the pre-update x and y.
    xs      = x_q >>> k_q;
    ys      = y_q >>> k_q;
    prod    = PW'(x_q) * PW'(GAIN);

    // Any pulse outside IDLE is ignored, including one on the SCALE edge.
    if (valid_in && (state_q != IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          x_d     = {{(IW-16){i_in[15]}}, i_in};
          y_d     = {{(IW-16){q_in[15]}}, q_in};
          state_d = PRE;
        end
      end

      // Fold the left half-plane onto the right by rotating through pi.
      // The result lies inside the CORDIC convergence range. Negating
      // -32768 is safe because of the IW headroom.
      PRE: begin
        if (x_q[IW-1]) begin
          x_d = -x_q;
          y_d = -y_q;
`ifdef HILBERT_ENV_PHASE_OUT_EN
          z_d = y_q[IW-1] ? -17'sd32768 : 17'sd32768;
        end else begin
          z_d = 17'sd0;
`endif
        end
        k_d     = 4'd0;
        state_d = ROT;
      end

      // Rotate toward y = 0. x grows by the CORDIC gain.
      ROT: begin
        if (!y_q[IW-1]) begin
          x_d = x_q + ys;
          y_d = y_q - xs;
`ifdef HILBERT_ENV_PHASE_OUT_EN
          z_d = z_q + atan_lut(k_q);
`endif
        end else begin
          x_d = x_q - ys;
          y_d = y_q + xs;
`ifdef HILBERT_ENV_PHASE_OUT_EN
          z_d = z_q - atan_lut(k_q);
`endif
        end
        k_d = k_q + 4'd1;
        if (k_q == 4'(ITERS - 1)) begin
          state_d = SCALE;
        end
      end

      SCALE: begin
        mag_d   = scale_sat(prod);
        vld_d   = 1'b1;
`ifdef HILBERT_ENV_PHASE_OUT_EN
        // Keeping the low 16 bits wraps +pi onto -pi; both are the same angle.
        phase_d = z_q[15:0];
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      mag_q   <= '0;
      vld_q   <= 1'b0;
      drop_q  <= '0;
`ifdef HILBERT_ENV_PHASE_OUT_EN
      z_q     <= '0;
      phase_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      mag_q   <= mag_d;
      vld_q   <= vld_d;
      drop_q  <= drop_d;
`ifdef HILBERT_ENV_PHASE_OUT_EN
      z_q     <= z_d;
      phase_q <= phase_d;
`endif
    end
  end

  assign mag_out   = mag_q;
  assign valid_out = vld_q;
  assign busy      = (state_q != IDLE);
  assign drop_cnt  = drop_q;
`ifdef HILBERT_ENV_PHASE_OUT_EN
  assign phase_out = phase_q;
`endif

endmodule

// File: tb/tb_hilbert_envelope_cordic.sv
`timescale 1ns/1ps
module tb_hilbert_envelope_cordic;
  localparam int ITERS = 14;
  localparam int IW    = 18;
  localparam int LAT   = ITERS + 2;
  localparam int PER   = ITERS + 3;
  localparam real PI   = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] i_in, q_in;
  logic               valid_in;
  logic        [15:0] mag_out;
  logic               valid_out, busy;
  logic        [7:0]  drop_cnt;
`ifdef HILBERT_ENV_PHASE_OUT_EN
  logic signed [15:0] phase_out;
`endif

  hilbert_envelope_cordic #(.ITERS(ITERS), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_in      (i_in),
    .q_in      (q_in),
    .valid_in  (valid_in),
    .mag_out   (mag_out),
    .valid_out (valid_out),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
`ifdef HILBERT_ENV_PHASE_OUT_EN
    ,
    .phase_out (phase_out)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vo_count = 0;

  typedef struct {
    int i;
    int q;
    int stamp;   // index of the accept edge
    int mtol;
    int ptol;    // negative: no phase check
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, bit ok, int act, int req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: true Euclidean magnitude.
  function automatic int ref_mag(int i, int q);
    real m;
    m = $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
    return int'(m);
  endfunction

  // Reference: angle in binary-angle units (pi = 32768).
  function automatic int ref_phase(int i, int q);
    real a;
    a = $atan2(real'(q), real'(i)) * 32768.0 / PI;
    return int'(a);
  endfunction

  // Angle difference wrapped into -32768..32767.
  function automatic int wrap_diff(int a, int b);
    int d;
    d = ((a - b) % 65536 + 65536 + 32768) % 65536 - 32768;
    return d;
  endfunction

  // Monitor: pops the scoreboard whenever a result is presented.
  always @(posedge clk) begin : mon
    exp_t e;
    int   m;
    #1;
    if (valid_out) begin
      vo_count++;
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 1'b0, 1, 0);
      end else begin
        e = sb.pop_front();
        check("latency", (cyc - e.stamp) == LAT, cyc - e.stamp, LAT);
        m = ref_mag(e.i, e.q);
        check("mag", iabs(int'(mag_out) - m) <= e.mtol, int'(mag_out), m);
`ifdef HILBERT_ENV_PHASE_OUT_EN
        if (e.ptol >= 0) begin
          m = ref_phase(e.i, e.q);
          check("phase", iabs(wrap_diff(int'(phase_out), m)) <= e.ptol,
                int'(phase_out), m);
        end
`endif
      end
    end
  end

  // Issue one accepted sample. The task returns at the negedge after the
  // accept edge.
  task automatic send(input int i, input int q, input int mt, input int pt);
    exp_t e;
    @(negedge clk);
    i_in = 16'(i);
    q_in = 16'(q);
    valid_in = 1'b1;
    e.i = i; e.q = q; e.stamp = cyc + 1; e.mtol = mt; e.ptol = pt;
    sb.push_back(e);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Single pulse that is expected to be dropped.
  task automatic pulse_drop(input int i, input int q);
    @(negedge clk);
    i_in = 16'(i);
    q_in = 16'(q);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic settle();
    repeat (PER + 2) @(negedge clk);
    check("drained", sb.size() == 0, sb.size(), 0);
  endtask

  initial begin
    int n, bcnt, ri, rq;
    exp_t e;
    rst = 1'b1;
    valid_in = 1'b0;
    i_in = '0;
    q_in = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_mag", mag_out == 16'd0, int'(mag_out), 0);
    check("rst_valid", valid_out == 1'b0, int'(valid_out), 0);
    check("rst_busy", busy == 1'b0, int'(busy), 0);
    check("rst_drop", drop_cnt == 8'd0, int'(drop_cnt), 0);
    rst = 1'b0;
    n = vo_count;
    repeat (50) @(negedge clk);
    check("idle_no_valid", vo_count == n, vo_count - n, 0);
    check("idle_busy", busy == 1'b0, int'(busy), 0);

    // First pair, with the busy window measured.
    send(3000, 4000, 3, 4);
    bcnt = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      if (busy) bcnt++;
      @(negedge clk);
    end
    check("busy_window", bcnt == LAT, bcnt, LAT);
    settle();

    // Axes, then the most negative corner.
    send(1000, 0, 2, 4);       settle();
    send(0, -1000, 2, 4);      settle();
    send(-1000, 0, 2, 4);      settle();
    send(-32768, -32768, 6, 4); settle();
    check("drop_none", drop_cnt == 8'd0, int'(drop_cnt), 0);

    // Three pulses 4 clocks apart: only the first is accepted.
    send(1234, -2345, 3, 4);
    repeat (2) @(negedge clk);
    pulse_drop(500, 500);
    repeat (2) @(negedge clk);
    pulse_drop(600, 600);
    settle();
    check("drop_two", drop_cnt == 8'd2, int'(drop_cnt), 2);

    // Continuous valid_in for 300 clocks: one accept per PER clocks.
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      ri = 7000 + j;
      rq = -3000 + 2 * j;
      i_in = 16'(ri);
      q_in = 16'(rq);
      valid_in = 1'b1;
      if (j % PER == 0) begin
        e.i = ri; e.q = rq; e.stamp = cyc + 1; e.mtol = 8; e.ptol = 8;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    settle();
    check("drop_sat", drop_cnt == 8'd255, int'(drop_cnt), 255);

    // Abort a computation with reset at edge 8.
    @(negedge clk);
    i_in = 16'sd20000;
    q_in = -16'sd15000;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (7) @(posedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_mag", mag_out == 16'd0, int'(mag_out), 0);
    check("abort_valid", valid_out == 1'b0, int'(valid_out), 0);
    check("abort_busy", busy == 1'b0, int'(busy), 0);
    check("abort_drop", drop_cnt == 8'd0, int'(drop_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = vo_count;
    repeat (30) @(negedge clk);
    check("abort_no_valid", vo_count == n, vo_count - n, 0);
    send(-2500, 6000, 3, 4);
    settle();

    // Randomized pairs.
    for (int t = 0; t < 40; t++) begin
      ri = int'($urandom_range(0, 65535)) - 32768;
      rq = int'($urandom_range(0, 65535)) - 32768;
      send(ri, rq, 8, (ref_mag(ri, rq) >= 1024) ? 16 : -1);
      settle();
    end

    check("final_drop", drop_cnt == 8'd0, int'(drop_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
